// File: rtl/cordic_fix2float.sv
// Q2.20 cosine to IEEE-754 single, one normalise shift per cycle; latency lz+2 (zero input: 2).
// Result held on out_valid until out_ready; samples arriving while busy are dropped and flag sticky overrun.
module cordic_fix2float #(
    parameter int IN_W     = 22,
    parameter int FRAC_W   = 20,
    parameter int EXP_BIAS = 127
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic            overrun
);

    localparam logic [7:0] EXP_INIT = 8'(EXP_BIAS + IN_W - 1 - FRAC_W);
    localparam int         PAD_W    = 24 - IN_W;

    typedef enum logic [1:0] {IDLE, NORM, PACK, HOLD} state_t;

    state_t          state;
    logic [IN_W-1:0] mag;
    logic [7:0]      exp;
    logic            sign;
    logic            zero;

    logic [IN_W-1:0] in_abs;
    logic            can_accept;

    // -2^(IN_W-1) negates to itself, which reads correctly as an unsigned magnitude.
    assign in_abs     = in_data[IN_W-1] ? IN_W'(-in_data) : in_data;
    assign can_accept = (state == IDLE) || (state == HOLD && out_ready);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mag       <= '0;
            exp       <= '0;
            sign      <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else if (clk_en) begin
            if (in_valid && !can_accept)
                overrun <= 1'b1;

            case (state)
                IDLE: ;
                NORM: begin
                    // Zero also spends the detect cycle here, so it shares the 2-cycle path of -2.0.
                    if (zero || mag[IN_W-1]) begin
                        state <= PACK;
                    end else begin
                        mag <= mag << 1;
                        exp <= exp - 8'd1;
                    end
                end
                PACK: begin
                    if (zero)
                        out_data <= 32'h0000_0000;
                    else
                        out_data <= {sign, exp, mag[IN_W-2:0], {PAD_W{1'b0}}};
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // A sample taken on the consuming edge of HOLD overrides the return to IDLE.
            if (in_valid && can_accept) begin
                sign  <= in_data[IN_W-1];
                mag   <= in_abs;
                exp   <= EXP_INIT;
                zero  <= (in_data == '0);
                state <= NORM;
                busy  <= 1'b1;
            end
        end
    end

endmodule
